// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared opcodes, constant words, fetch FSM states and immediate decoders for the fetch stage
package if_fetch_pkg;
    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [INST_W-1:0] ZERO_WORD = 32'h0;
    localparam logic [INST_W-1:0] NOP_INST  = 32'h0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} fetch_state_t;
    function automatic logic [INST_ADDR_W-1:0] j_imm(input logic [INST_W-1:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction
    function automatic logic [INST_ADDR_W-1:0] b_imm(input logic [INST_W-1:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction
endpackage

// File: rtl/if_bht.sv
// if_bht: branch history table of 2-bit saturating counters, one read port and one update port
//  clk, rst_n   clock, async active-low reset (counters reset to weakly not-taken)
//  rd_idx       lookup index; rd_taken = MSB of the counter (read sees pre-update value)
//  upd_en       apply an update this cycle at upd_idx with outcome upd_taken
module if_bht import if_fetch_pkg::*; #(
    parameter int ENTRIES = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx,
    output logic                       rd_taken,
    input  logic                       upd_en,
    input  logic [$clog2(ENTRIES)-1:0] upd_idx,
    input  logic                       upd_taken
);
    logic [1:0] ctr [ENTRIES];
    logic [1:0] cur;
    assign rd_taken = ctr[rd_idx][1];
    assign cur = ctr[upd_idx];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
        end else if (upd_en) begin
            ctr[upd_idx] <= upd_taken ? (cur == 2'b11 ? cur : cur + 2'd1)
                                      : (cur == 2'b00 ? cur : cur - 2'd1);
        end
    end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with direct-mapped I-cache, static JAL / BHT branch prediction
//  clk, rst_n          clock, async active-low reset
//  rdy                 global ready, low freezes all state
//  stall_i             hold pc and IF/ID outputs
//  jump_i/jump_addr_i  EX redirect (highest priority)
//  bht_upd_*           resolved conditional branch outcome for the BHT
//  mem_req_o/addr_o    miss request to memory controller, held until mem_done_i
//  mem_done_i/inst_i   one-cycle fill response
//  pc_o/inst_o/taken_o IF/ID outputs; inst_o = 0 is a bubble
module if_fetch import if_fetch_pkg::*; #(
    parameter int ICACHE_ENTRIES = 64,
    parameter int BHT_ENTRIES    = 128,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        bht_upd_i,
    input  logic [31:0] bht_upd_pc_i,
    input  logic        bht_upd_taken_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        taken_o
);
    localparam int CI = $clog2(ICACHE_ENTRIES);
    localparam int BI = $clog2(BHT_ENTRIES);
    localparam int TW = INST_ADDR_W - CI - 2;

    fetch_state_t state, state_nxt;
    logic [31:0] pc, pc_nxt, hold_data, hold_nxt, addr_nxt, pco_nxt, insto_nxt;
    logic discard, discard_nxt, req_nxt, tko_nxt, fill, emit;
    logic [ICACHE_ENTRIES-1:0] c_valid;
    logic [TW-1:0] c_tag [ICACHE_ENTRIES];
    logic [INST_W-1:0] c_data [ICACHE_ENTRIES];
    logic [CI-1:0] idx, fill_idx;
    logic hit, bht_taken, is_jal, is_brt, pred_taken;
    logic [31:0] fw, pred_pc;
    logic unused_bits;

    assign idx = pc[CI+1:2];
    assign fill_idx = mem_addr_o[CI+1:2];
    assign hit = c_valid[idx] && c_tag[idx] == pc[31:CI+2];
    // the word being emitted comes from the fill bus in WAIT, the holding reg in HOLD, else the cache
    assign fw = state == S_WAIT ? mem_inst_i : state == S_HOLD ? hold_data : c_data[idx];
    assign is_jal = fw[6:0] == OPC_JAL;
    assign is_brt = fw[6:0] == OPC_BRANCH && bht_taken;
    assign pred_taken = is_jal || is_brt;
    assign pred_pc = pc + (is_jal ? j_imm(fw) : is_brt ? b_imm(fw) : 32'd4);
    assign unused_bits = ^{bht_upd_pc_i[31:BI+2], bht_upd_pc_i[1:0]};

    if_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (pc[BI+1:2]),
        .rd_taken (bht_taken),
        .upd_en   (rdy && bht_upd_i),
        .upd_idx  (bht_upd_pc_i[BI+1:2]),
        .upd_taken(bht_upd_taken_i)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt = pc;
        discard_nxt = discard;
        hold_nxt = hold_data;
        req_nxt = mem_req_o;
        addr_nxt = mem_addr_o;
        pco_nxt = pc_o;
        insto_nxt = inst_o;
        tko_nxt = taken_o;
        fill = FALSE;
        emit = FALSE;
        if (rdy) begin
            case (state)
                S_IDLE: if (!jump_i) begin
                    if (hit) begin
                        emit = !stall_i;
                    end else begin
                        // a miss launches even under stall so the fill overlaps the stall
                        req_nxt = TRUE;
                        addr_nxt = pc;
                        discard_nxt = FALSE;
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: if (mem_done_i) begin
                    fill = TRUE;
                    req_nxt = FALSE;
                    discard_nxt = FALSE;
                    state_nxt = S_IDLE;
                    if (!jump_i && !discard) begin
                        if (stall_i) begin
                            hold_nxt = mem_inst_i;
                            state_nxt = S_HOLD;
                        end else begin
                            emit = TRUE;
                        end
                    end
                end else if (jump_i) begin
                    // the controller cannot abort, so remember to drop the word when it lands
                    discard_nxt = TRUE;
                end
                S_HOLD: if (jump_i) begin
                    state_nxt = S_IDLE;
                end else if (!stall_i) begin
                    emit = TRUE;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
            pc_nxt = jump_i ? jump_addr_i : emit ? pred_pc : pc;
            if (emit) begin
                pco_nxt = pc;
                insto_nxt = fw;
                tko_nxt = pred_taken;
            end else if (jump_i || !stall_i) begin
                // nothing to hand over: send a bubble so ID never re-executes the last word
                pco_nxt = ZERO_WORD;
                insto_nxt = NOP_INST;
                tko_nxt = FALSE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc <= RESET_PC;
            discard <= FALSE;
            hold_data <= ZERO_WORD;
            mem_req_o <= FALSE;
            mem_addr_o <= ZERO_WORD;
            pc_o <= ZERO_WORD;
            inst_o <= NOP_INST;
            taken_o <= FALSE;
            c_valid <= '0;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
            discard <= discard_nxt;
            hold_data <= hold_nxt;
            mem_req_o <= req_nxt;
            mem_addr_o <= addr_nxt;
            pc_o <= pco_nxt;
            inst_o <= insto_nxt;
            taken_o <= tko_nxt;
            if (fill) c_valid[fill_idx] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            c_tag[fill_idx] <= mem_addr_o[31:CI+2];
            c_data[fill_idx] <= mem_inst_i;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenario bench for the fetch stage
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst_n, rdy, stall_i, jump_i, bht_upd_i, bht_upd_taken_i, mem_done_i;
    logic [31:0] jump_addr_i, bht_upd_pc_i, mem_inst_i;
    logic        mem_req_o, taken_o;
    logic [31:0] mem_addr_o, pc_o, inst_o;
    int total = 0;
    int bad = 0;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_JAL  = 32'h0100006F;
    localparam logic [31:0] I_BEQ  = 32'hFE000CE3;
    localparam logic [31:0] I_40   = 32'h00000213;
    localparam logic [31:0] I_100  = 32'h00000293;

    logic [31:0] prog_a [7] = '{32'h0, 32'h4, 32'h8, 32'h18, 32'h1C, 32'h20, 32'h24};
    logic [31:0] prog_d [7] = '{I_ADDI, 32'h00108113, I_JAL, 32'h00100193, 32'h00118193, I_BEQ, 32'h00000013};
    logic        prog_t [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    if_fetch dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .stall_i(stall_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .bht_upd_i(bht_upd_i), .bht_upd_pc_i(bht_upd_pc_i), .bht_upd_taken_i(bht_upd_taken_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_done_i(mem_done_i), .mem_inst_i(mem_inst_i),
        .pc_o(pc_o), .inst_o(inst_o), .taken_o(taken_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic serve(input logic [31:0] data, input int dly, output logic [31:0] addr, output logic seen);
        for (int i = 0; i < 20 && mem_req_o !== 1'b1; i++) tick();
        seen = mem_req_o === 1'b1;
        addr = mem_addr_o;
        repeat (dly) tick();
        mem_done_i = 1'b1;
        mem_inst_i = data;
        tick();
        mem_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = 32'h0;
        bht_upd_i = 1'b0; bht_upd_pc_i = 32'h0; bht_upd_taken_i = 1'b0;
        mem_done_i = 1'b0; mem_inst_i = 32'h0;
        repeat (2) tick();
        total++; if ({mem_req_o, taken_o} !== 2'b00) begin bad++; $display("FAIL rst_flags: got req=%0b taken=%0b want 0 0", mem_req_o, taken_o); end
        total++; if ({pc_o, inst_o, mem_addr_o} !== 96'h0) begin bad++; $display("FAIL rst_regs: got pc=%h inst=%h addr=%h want 0", pc_o, inst_o, mem_addr_o); end
        rst_n = 1'b1;
        tick();
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin bad++; $display("FAIL first_req: got req=%0b addr=%h want 1 0", mem_req_o, mem_addr_o); end
        repeat (2) tick();
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin bad++; $display("FAIL req_stable: got req=%0b addr=%h want 1 0", mem_req_o, mem_addr_o); end
        mem_done_i = 1'b1; mem_inst_i = I_ADDI;
        tick();
        mem_done_i = 1'b0;
        total++; if (inst_o !== I_ADDI || pc_o !== 32'h0 || taken_o !== 1'b0) begin bad++; $display("FAIL first_emit: got pc=%h inst=%h tk=%0b want 0 %h 0", pc_o, inst_o, taken_o, I_ADDI); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL req_drop: got %0b want 0", mem_req_o); end
        tick();
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin bad++; $display("FAIL pc_plus4: got req=%0b addr=%h want 1 4", mem_req_o, mem_addr_o); end
    endtask

    task automatic test_fill();
        logic [31:0] a;
        logic s;
        for (int k = 1; k < 7; k++) begin
            serve(prog_d[k], 1, a, s);
            total++; if (s !== 1'b1 || a !== prog_a[k]) begin bad++; $display("FAIL fill_req[%0d]: got seen=%0b addr=%h want 1 %h", k, s, a, prog_a[k]); end
            total++; if (pc_o !== prog_a[k] || inst_o !== prog_d[k] || taken_o !== prog_t[k]) begin bad++; $display("FAIL fill_emit[%0d]: got pc=%h inst=%h tk=%0b want %h %h %0b", k, pc_o, inst_o, taken_o, prog_a[k], prog_d[k], prog_t[k]); end
        end
    endtask

    task automatic test_loop();
        for (int i = 0; i < 20 && mem_req_o !== 1'b1; i++) tick();
        jump_i = 1'b1; jump_addr_i = 32'h0;
        tick();
        jump_i = 1'b0;
        total++; if (inst_o !== 32'h0 || pc_o !== 32'h0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h28) begin bad++; $display("FAIL loop_jump: got pc=%h inst=%h req=%0b addr=%h want 0 0 1 28", pc_o, inst_o, mem_req_o, mem_addr_o); end
        mem_done_i = 1'b1; mem_inst_i = 32'h00000013;
        tick();
        mem_done_i = 1'b0;
        total++; if (mem_req_o !== 1'b0 || inst_o !== 32'h0) begin bad++; $display("FAIL loop_discard: got req=%0b inst=%h want 0 0", mem_req_o, inst_o); end
        for (int k = 0; k < 7; k++) begin
            tick();
            total++; if (pc_o !== prog_a[k] || inst_o !== prog_d[k] || taken_o !== prog_t[k] || mem_req_o !== 1'b0) begin bad++; $display("FAIL loop_hit[%0d]: got pc=%h inst=%h tk=%0b req=%0b want %h %h %0b 0", k, pc_o, inst_o, taken_o, mem_req_o, prog_a[k], prog_d[k], prog_t[k]); end
        end
    endtask

    task automatic test_bht();
        jump_i = 1'b1; jump_addr_i = 32'h18;
        bht_upd_i = 1'b1; bht_upd_pc_i = 32'h20; bht_upd_taken_i = 1'b1;
        tick();
        jump_i = 1'b0;
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL bht_bubble: got inst=%h want 0", inst_o); end
        tick();
        bht_upd_i = 1'b0;
        total++; if (pc_o !== 32'h18) begin bad++; $display("FAIL bht_f18: got pc=%h want 18", pc_o); end
        repeat (2) tick();
        total++; if (pc_o !== 32'h20 || taken_o !== 1'b1) begin bad++; $display("FAIL bht_taken: got pc=%h tk=%0b want 20 1", pc_o, taken_o); end
        tick();
        total++; if (pc_o !== 32'h18 || taken_o !== 1'b0) begin bad++; $display("FAIL bht_target: got pc=%h tk=%0b want 18 0", pc_o, taken_o); end
        stall_i = 1'b1; bht_upd_i = 1'b1; bht_upd_taken_i = 1'b1;
        tick();
        bht_upd_taken_i = 1'b0;
        repeat (2) tick();
        bht_upd_i = 1'b0;
        total++; if (pc_o !== 32'h18) begin bad++; $display("FAIL bht_stall_hold: got pc=%h want 18", pc_o); end
        stall_i = 1'b0;
        repeat (2) tick();
        total++; if (pc_o !== 32'h20 || taken_o !== 1'b0) begin bad++; $display("FAIL bht_sat_hi: got pc=%h tk=%0b want 20 0", pc_o, taken_o); end
        tick();
        total++; if (pc_o !== 32'h24) begin bad++; $display("FAIL bht_fallthru: got pc=%h want 24", pc_o); end
        jump_i = 1'b1; jump_addr_i = 32'h18;
        tick();
        jump_i = 1'b0; stall_i = 1'b1; bht_upd_i = 1'b1; bht_upd_taken_i = 1'b0;
        repeat (2) tick();
        bht_upd_taken_i = 1'b1;
        repeat (2) tick();
        bht_upd_i = 1'b0; stall_i = 1'b0;
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL bht_stall_bubble: got inst=%h want 0", inst_o); end
        repeat (3) tick();
        total++; if (pc_o !== 32'h20 || taken_o !== 1'b1) begin bad++; $display("FAIL bht_sat_lo: got pc=%h tk=%0b want 20 1", pc_o, taken_o); end
        tick();
        total++; if (pc_o !== 32'h18) begin bad++; $display("FAIL bht_redirect: got pc=%h want 18", pc_o); end
    endtask

    task automatic test_jump_wait();
        logic [31:0] a;
        logic s;
        jump_i = 1'b1; jump_addr_i = 32'h40;
        tick();
        jump_i = 1'b0;
        tick();
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin bad++; $display("FAIL jw_req40: got req=%0b addr=%h want 1 40", mem_req_o, mem_addr_o); end
        jump_i = 1'b1; jump_addr_i = 32'h100;
        tick();
        jump_i = 1'b0;
        total++; if (inst_o !== 32'h0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin bad++; $display("FAIL jw_hold: got inst=%h req=%0b addr=%h want 0 1 40", inst_o, mem_req_o, mem_addr_o); end
        mem_done_i = 1'b1; mem_inst_i = I_40;
        tick();
        mem_done_i = 1'b0;
        total++; if (mem_req_o !== 1'b0 || inst_o !== 32'h0) begin bad++; $display("FAIL jw_drop: got req=%0b inst=%h want 0 0", mem_req_o, inst_o); end
        tick();
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin bad++; $display("FAIL jw_req100: got req=%0b addr=%h want 1 100", mem_req_o, mem_addr_o); end
        serve(I_100, 2, a, s);
        total++; if (s !== 1'b1 || pc_o !== 32'h100 || inst_o !== I_100 || taken_o !== 1'b0) begin bad++; $display("FAIL jw_emit100: got seen=%0b pc=%h inst=%h tk=%0b want 1 100 %h 0", s, pc_o, inst_o, taken_o, I_100); end
        tick();
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104) begin bad++; $display("FAIL jw_req104: got req=%0b addr=%h want 1 104", mem_req_o, mem_addr_o); end
        jump_i = 1'b1; jump_addr_i = 32'h40; mem_done_i = 1'b1; mem_inst_i = 32'h00000013;
        tick();
        jump_i = 1'b0; mem_done_i = 1'b0;
        total++; if (inst_o !== 32'h0 || mem_req_o !== 1'b0) begin bad++; $display("FAIL jw_same_cycle: got inst=%h req=%0b want 0 0", inst_o, mem_req_o); end
        tick();
        total++; if (pc_o !== 32'h40 || inst_o !== I_40 || mem_req_o !== 1'b0) begin bad++; $display("FAIL jw_cached40: got pc=%h inst=%h req=%0b want 40 %h 0", pc_o, inst_o, mem_req_o, I_40); end
    endtask

    task automatic test_stall();
        jump_i = 1'b1; jump_addr_i = 32'h18;
        tick();
        jump_i = 1'b0;
        tick();
        total++; if (pc_o !== 32'h18) begin bad++; $display("FAIL st_start: got pc=%h want 18", pc_o); end
        stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (pc_o !== 32'h18 || inst_o !== 32'h00100193 || mem_req_o !== 1'b0) begin bad++; $display("FAIL st_hold[%0d]: got pc=%h inst=%h req=%0b want 18 00100193 0", k, pc_o, inst_o, mem_req_o); end
        end
        stall_i = 1'b0;
        tick();
        total++; if (pc_o !== 32'h1C) begin bad++; $display("FAIL st_release: got pc=%h want 1c", pc_o); end
        rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (pc_o !== 32'h1C) begin bad++; $display("FAIL rdy_freeze[%0d]: got pc=%h want 1c", k, pc_o); end
        end
        rdy = 1'b1;
        tick();
        total++; if (pc_o !== 32'h20 || taken_o !== 1'b1) begin bad++; $display("FAIL rdy_resume: got pc=%h tk=%0b want 20 1", pc_o, taken_o); end
    endtask

    task automatic test_reset_wait();
        jump_i = 1'b1; jump_addr_i = 32'h200;
        tick();
        jump_i = 1'b0; stall_i = 1'b1;
        tick();
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin bad++; $display("FAIL prefetch_stall: got req=%0b addr=%h want 1 200", mem_req_o, mem_addr_o); end
        stall_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || inst_o !== 32'h0 || pc_o !== 32'h0) begin bad++; $display("FAIL async_rst: got req=%0b addr=%h inst=%h pc=%h want 0 0 0 0", mem_req_o, mem_addr_o, inst_o, pc_o); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_invalidate: got req=%0b addr=%h want 1 0", mem_req_o, mem_addr_o); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_loop();
        test_bht();
        test_jump_wait();
        test_stall();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
